// File: rtl/ex_hazard_ctl.sv
// Execute-stage sequencing: load-use bubbles, branch/jump flushes,
// MDU hold with watchdog, and a saturating stall-cycle counter.
module ex_hazard_ctl #(
  parameter int reg_addr_width = 5,
  parameter int mdu_max_cycles = 64,
  parameter int cnt_width      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [reg_addr_width-1:0] id_rs1,
  input  logic [reg_addr_width-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [reg_addr_width-1:0] ex_rd_addr,
  input  logic                      ex_rd_wen,
  input  logic                      ex_mem_ctl,
  input  logic                      ex_jmp_ctl,
  input  logic                      ex_bch_ctl,
  input  logic                      ex_bch_taken,
  input  logic                      ex_mdu_op,
  input  logic                      mdu_done,
  input  logic                      cnt_clr,
  output logic                      stall_pc,
  output logic                      stall_id,
  output logic                      stall_ex,
  output logic                      bubble_ex,
  output logic                      flush_if_id,
  output logic                      flush_id_ex,
  output logic                      redirect,
  output logic                      mdu_start,
  output logic                      mdu_err,
  output logic [cnt_width-1:0]      stall_cnt
);

  typedef enum logic {
    S_RUN,
    S_BUSY
  } state_t;

  localparam int WDW = $clog2(mdu_max_cycles) + 1;

  state_t                r_state;
  logic [WDW-1:0]        r_wd;
  logic                  r_err;
  logic [cnt_width-1:0]  r_cnt;

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_ld_use;
  logic w_take;
  logic w_wd_exp;

  assign w_rs1_hit = id_rs1_used & (id_rs1 == ex_rd_addr);
  assign w_rs2_hit = id_rs2_used & (id_rs2 == ex_rd_addr);
  assign w_ld_use  = ex_mem_ctl & ex_rd_wen & (|ex_rd_addr)
                   & (w_rs1_hit | w_rs2_hit);
  assign w_take    = ex_jmp_ctl | (ex_bch_ctl & ex_bch_taken);
  assign w_wd_exp  = (r_wd == WDW'(mdu_max_cycles - 1));

  // Gated by rst_n so every output drops the instant reset asserts.
  always_comb begin
    stall_pc    = 1'b0;
    stall_id    = 1'b0;
    stall_ex    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    redirect    = 1'b0;
    mdu_start   = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        S_RUN: begin
          if (ex_mdu_op) begin
            mdu_start = 1'b1;
            stall_pc  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
          end else if (w_take) begin
            redirect    = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (w_ld_use) begin
            stall_pc  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
          end
        end
        S_BUSY: begin
          if (mdu_done) begin
            redirect    = w_take;
            flush_if_id = w_take;
            flush_id_ex = w_take;
          end else if (!w_wd_exp) begin
            stall_pc = 1'b1;
            stall_id = 1'b1;
            stall_ex = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_wd    <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          if (ex_mdu_op) begin
            r_state <= S_BUSY;
            r_wd    <= '0;
          end
        end
        S_BUSY: begin
          if (mdu_done) begin
            r_state <= S_RUN;
          end else if (w_wd_exp) begin
            r_err   <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (stall_pc && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign mdu_err   = r_err;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_ex_hazard_ctl.sv
// Directed bench for ex_hazard_ctl: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_ex_hazard_ctl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] ex_rd_addr;
  logic       ex_rd_wen;
  logic       ex_mem_ctl;
  logic       ex_jmp_ctl;
  logic       ex_bch_ctl;
  logic       ex_bch_taken;
  logic       ex_mdu_op;
  logic       mdu_done;
  logic       cnt_clr;
  logic       stall_pc;
  logic       stall_id;
  logic       stall_ex;
  logic       bubble_ex;
  logic       flush_if_id;
  logic       flush_id_ex;
  logic       redirect;
  logic       mdu_start;
  logic       mdu_err;
  logic [3:0] stall_cnt;

  ex_hazard_ctl #(
    .reg_addr_width(5),
    .mdu_max_cycles(8),
    .cnt_width(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr),
    .ex_rd_wen(ex_rd_wen),
    .ex_mem_ctl(ex_mem_ctl),
    .ex_jmp_ctl(ex_jmp_ctl),
    .ex_bch_ctl(ex_bch_ctl),
    .ex_bch_taken(ex_bch_taken),
    .ex_mdu_op(ex_mdu_op),
    .mdu_done(mdu_done),
    .cnt_clr(cnt_clr),
    .stall_pc(stall_pc),
    .stall_id(stall_id),
    .stall_ex(stall_ex),
    .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex),
    .redirect(redirect),
    .mdu_start(mdu_start),
    .mdu_err(mdu_err),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    string       name;
    logic [12:0] exp;
  } item_t;

  item_t q[$];
  int    checks = 0;
  int    errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc,id,ex,bub,fif,fie,red,start,err,cnt[3:0]}
  function automatic logic [12:0] mk(
    input logic pc, input logic id, input logic ex, input logic bub,
    input logic fl, input logic st, input logic err, input int cnt);
    return {pc, id, ex, bub, fl, fl, fl, st, err, 4'(cnt)};
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      item_t       it;
      logic [12:0] act;
      it  = q.pop_front();
      act = {stall_pc, stall_id, stall_ex, bubble_ex, flush_if_id,
             flush_id_ex, redirect, mdu_start, mdu_err, stall_cnt};
      checks++;
      if (act !== it.exp) begin
        errors++;
        $display("FAIL %s got %b want %b", it.name, act, it.exp);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    id_rs1       = '0;
    id_rs2       = '0;
    id_rs1_used  = 1'b0;
    id_rs2_used  = 1'b0;
    ex_rd_addr   = '0;
    ex_rd_wen    = 1'b0;
    ex_mem_ctl   = 1'b0;
    ex_jmp_ctl   = 1'b0;
    ex_bch_ctl   = 1'b0;
    ex_bch_taken = 1'b0;
    ex_mdu_op    = 1'b0;
    mdu_done     = 1'b0;
    cnt_clr      = 1'b0;
  endtask

  task automatic push(input string n, input logic [12:0] e);
    item_t it;
    it.name = n;
    it.exp  = e;
    q.push_back(it);
  endtask

  task automatic ld_use5();
    ex_mem_ctl  = 1'b1;
    ex_rd_wen   = 1'b1;
    ex_rd_addr  = 5'd5;
    id_rs1      = 5'd5;
    id_rs1_used = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    cyc();
    push("reset", mk(0,0,0,0,0,0,0,0));
    cyc(); rst_n = 1'b1;
    push("idle", mk(0,0,0,0,0,0,0,0));
    cyc(); ld_use5();
    push("ld_use", mk(1,1,0,1,0,0,0,0));
    cyc();
    push("ld_after", mk(0,0,0,0,0,0,0,1));
    cyc(); ld_use5(); ex_rd_addr = 5'd0; id_rs1 = 5'd0;
    push("ld_x0", mk(0,0,0,0,0,0,0,1));
    cyc(); ld_use5(); id_rs1 = 5'd7; id_rs2 = 5'd5;
    push("ld_rs2_unused", mk(0,0,0,0,0,0,0,1));
    cyc(); ld_use5(); ex_bch_ctl = 1'b1; ex_bch_taken = 1'b1;
    push("bch_over_ld", mk(0,0,0,0,1,0,0,1));
    cyc(); ex_bch_ctl = 1'b1;
    push("bch_not_taken", mk(0,0,0,0,0,0,0,1));
    cyc(); ex_jmp_ctl = 1'b1;
    push("jmp", mk(0,0,0,0,1,0,0,1));
    cyc(); cnt_clr = 1'b1;
    push("clr", mk(0,0,0,0,0,0,0,1));
    cyc(); ex_mdu_op = 1'b1;
    push("mdu_start", mk(1,1,1,0,0,1,0,0));
    for (int i = 1; i <= 3; i++) begin
      cyc(); ex_mdu_op = 1'b1;
      push("mdu_busy", mk(1,1,1,0,0,0,0,i));
    end
    cyc(); ex_mdu_op = 1'b1; mdu_done = 1'b1;
    push("mdu_done", mk(0,0,0,0,0,0,0,4));
    cyc(); ex_mdu_op = 1'b1;
    push("mdu_b2b", mk(1,1,1,0,0,1,0,4));
    cyc(); ex_mdu_op = 1'b1; mdu_done = 1'b1;
    ex_bch_ctl = 1'b1; ex_bch_taken = 1'b1;
    push("mdu_done_take", mk(0,0,0,0,1,0,0,5));
    cyc(); mdu_done = 1'b1;
    push("done_in_run", mk(0,0,0,0,0,0,0,5));
    cyc(); ex_mdu_op = 1'b1;
    push("wd_start", mk(1,1,1,0,0,1,0,5));
    for (int i = 0; i < 7; i++) begin
      cyc(); ex_mdu_op = 1'b1;
      push("wd_busy", mk(1,1,1,0,0,0,0,6 + i));
    end
    cyc(); ex_mdu_op = 1'b1;
    push("wd_expire", mk(0,0,0,0,0,0,0,13));
    cyc();
    push("err_sticky", mk(0,0,0,0,0,0,1,13));
    cyc(); ex_mdu_op = 1'b1;
    push("start_after_err", mk(1,1,1,0,0,1,1,13));
    cyc(); ex_mdu_op = 1'b1;
    push("busy_after_err", mk(1,1,1,0,0,0,1,14));
    cyc(); ex_mdu_op = 1'b1; rst_n = 1'b0;
    push("async_rst", mk(0,0,0,0,0,0,0,0));
    cyc(); rst_n = 1'b1; mdu_done = 1'b1;
    push("late_done", mk(0,0,0,0,0,0,0,0));
    for (int i = 0; i < 20; i++) begin
      cyc(); ld_use5();
      push("sat", mk(1,1,0,1,0,0,0,(i > 15) ? 15 : i));
    end
    cyc(); ld_use5(); cnt_clr = 1'b1;
    push("clr_with_stall", mk(1,1,0,1,0,0,0,15));
    cyc();
    push("cleared", mk(0,0,0,0,0,0,0,0));
    cyc();
    cyc();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctl.md
# ex_hazard_ctl

Pipeline sequencing controller for the execute stage. It detects load-use hazards that forwarding cannot cover and inserts bubbles. It resolves jumps and taken branches with front-end flushes, and holds the pipeline while a multi-cycle multiply/divide unit (MDU) attached to EX completes. It also keeps a saturating count of stall cycles for performance analysis.

## Interface
- reg_addr_width, 5, register address width
- mdu_max_cycles, 64, watchdog limit on MDU busy cycles (≥2)
- cnt_width, 32, stall counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  reg_addr_width  source registers of the instruction in ID
- id_rs1_used, id_rs2_used  in  1  the ID instruction actually reads that source
- ex_rd_addr  in  reg_addr_width  destination of the EX instruction
- ex_rd_wen  in  1  EX instruction writes rd
- ex_mem_ctl  in  1  EX instruction is a load
- ex_jmp_ctl  in  1  EX instruction is JAL/JALR
- ex_bch_ctl  in  1  EX instruction is a branch
- ex_bch_taken  in  1  branch condition result from the ALU
- ex_mdu_op  in  1  EX instruction is a multi-cycle MDU op
- mdu_done  in  1  MDU result valid (single-cycle pulse)
- cnt_clr  in  1  synchronous clear of stall counter
- stall_pc  out  1  hold the PC
- stall_id  out  1  hold the IF/ID register
- stall_ex  out  1  hold the ID/EX register (EX instruction stays)
- bubble_ex  out  1  load a NOP into ID/EX
- flush_if_id, flush_id_ex  out  1  squash the younger instructions
- redirect  out  1  PC takes the EX target address
- mdu_start  out  1  one-cycle start pulse to the MDU
- mdu_err  out  1  sticky watchdog error
- stall_cnt  out  cnt_width  saturating count of stall_pc cycles

## Operation
- FSM states:
  - RUN (reset)
  - MDU_BUSY
- Hazard terms:
  - ld_use = ex_mem_ctl & ex_rd_wen & ex_rd_addr≠0 & ((id_rs1_used & id_rs1==ex_rd_addr) | (id_rs2_used & id_rs2==ex_rd_addr)). Register x0 never creates a hazard.
  - take = ex_jmp_ctl | (ex_bch_ctl & ex_bch_taken).
- RUN with ex_mdu_op:
  - assert mdu_start, stall_pc, stall_id, stall_ex
  - clear the watchdog counter
  - next state MDU_BUSY
  - ld_use and take are ignored this cycle
- MDU_BUSY while mdu_done=0:
  - assert stall_pc, stall_id, stall_ex
  - increment the watchdog counter
  - if the watchdog counter reaches mdu_max_cycles-1: set mdu_err, release all stalls, go to RUN
- MDU_BUSY with mdu_done=1:
  - drop all stalls
  - next state RUN
  - take is evaluated this cycle and redirects if set
- RUN, no ex_mdu_op, take=1:
  - assert redirect, flush_if_id, flush_id_ex
  - no stall
  - take overrides ld_use, because the ID instruction is squashed anyway
- RUN, no ex_mdu_op, take=0, ld_use=1:
  - assert stall_pc, stall_id, bubble_ex for exactly one cycle
  - in the next cycle the load sits in MEM and forwarding covers the hazard
- stall_ex and bubble_ex are never asserted together.
- Outputs are combinational from the state and inputs.
- State, the watchdog counter, mdu_err and stall_cnt are registered.
- stall_cnt:
  - +1 on each cycle with stall_pc=1
  - saturates at all-ones
  - cnt_clr takes priority and clears it to 0
- mdu_err clears only on reset.

## Timing
- Reset (async assert, sync release by the system):
  - state=RUN, watchdog=0, mdu_err=0, stall_cnt=0
  - with inputs low, every output is 0
- Load-use costs one bubble cycle.
- Taken branch or jump costs two squashed slots, with redirect in the EX cycle.
- MDU op whose done arrives k cycles after the start cycle: stall_pc is high for k cycles (start cycle through the cycle before done) and low in the done cycle. The EX register captures the next instruction at the done edge.
- A back-to-back MDU op re-enters MDU_BUSY on the following cycle with a fresh mdu_start.
- Reset during MDU_BUSY returns to RUN immediately. Any late mdu_done is ignored in RUN.
- mdu_done while in RUN has no effect.

## Test plan
- Load to x5 in EX; ID reads rs1=5 with id_rs1_used=1 -> one cycle of stall_pc=stall_id=bubble_ex=1; stall_cnt=1. Repeat with ex_rd_addr=0 -> no stall.
- Branch in EX, ex_bch_taken=1, with a load-use also present -> redirect=flush_if_id=flush_id_ex=1, stall_pc=0.
- MDU op with mdu_done 4 cycles after start -> mdu_start is a single pulse; stall_ex is high for 4 cycles; the done cycle has no stall; stall_cnt=4.
- mdu_max_cycles=8 and mdu_done never asserted -> stalls drop after 8 cycles, mdu_err=1 and stays set; next MDU op still issues mdu_start.
- Assert rst_n=0 mid MDU_BUSY -> all outputs 0 asynchronously; a late mdu_done after release causes no action.
- Force stall_cnt to all-ones with cnt_width=4 plus 20 stall cycles -> holds 15; cnt_clr together with a stall cycle -> 0.
